// File: rtl/ren_conv_pkg.sv
// ren_conv_pkg: shared definitions for the convolver loader slice.
//   - FSM state encoding for the Wishbone burst loader
//   - default top address byte of convolver instance 0
//   - instance-select width and per-word byte stride
//   - helpers for the instance address byte and the bus-state decode
package ren_conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_FETCH = 3'd1,
        ST_WR_BUS   = 3'd2,
        ST_RD_BUS   = 3'd3,
        ST_RD_PUSH  = 3'd4,
        ST_FINISH   = 3'd5
    } ren_state_e;

    localparam logic [7:0]  REN_BASE_ADDR_HI = 8'h30;
    localparam int          REN_INST_W       = 2;
    localparam logic [23:0] REN_BYTE_STRIDE  = 24'd4;

    // Top address byte of an instance: plain 8-bit add, no carry beyond.
    function automatic logic [7:0] ren_inst_hi(input logic [7:0] base,
                                               input logic [REN_INST_W-1:0] inst);
        return base + 8'(inst);
    endfunction

    // True in the two states that hold a Wishbone cycle open.
    function automatic logic ren_is_bus(input ren_state_e st);
        return (st == ST_WR_BUS) || (st == ST_RD_BUS);
    endfunction

endpackage

// File: rtl/ren_wb_timer.sv
// ren_wb_timer: bus-ack timeout counter shared by Wishbone masters.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   load   : hold the count at zero (asserted whenever no bus cycle is open)
//   en     : count one waiting cycle (bus cycle open and no ack this cycle)
//   expire : this waiting cycle is the TIMEOUT_CYCLES-th one in a row
module ren_wb_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_WIDTH       = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [TO_WIDTH-1:0] LAST_CNT = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_WIDTH-1:0] ONE_CNT  = TO_WIDTH'(1);

    logic [TO_WIDTH-1:0] cnt_r;

    // Waiting-cycle counter: cleared while idle, stepped on each unacked cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {TO_WIDTH{1'b0}};
        end else if (load) begin
            cnt_r <= {TO_WIDTH{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + ONE_CNT;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Expiry is qualified by en, so an ack in the same cycle always wins.
    assign expire = en & ~load & (cnt_r == LAST_CNT);

endmodule

// File: rtl/ren_conv_loader.sv
// ren_conv_loader: Wishbone classic master feeding the 4-instance convolver.
// Moves one descriptor-defined burst of 32-bit words per command:
//   write: s_* stream -> instance window;  read: instance window -> m_* stream.
// Ports:
//   wb_clk_i / wb_rst_i        clock / async active-low reset
//   cmd_*                      descriptor handshake (rd, inst, offset, len)
//   s_valid_i/s_data_i/s_ready_o   input word stream (write direction)
//   m_valid_o/m_data_o/m_ready_i   output word stream (read direction)
//   wbm_*                      Wishbone classic master
//   busy_o / done_o / err_o    status; done_o pulses at end of every command,
//                              err_o pulses with it on a bus timeout
module ren_conv_loader
    import ren_conv_pkg::*;
#(
    parameter int         LEN_WIDTH      = 8,
    parameter int         TIMEOUT_CYCLES = 16,
    parameter int         TO_WIDTH       = 5,
    parameter logic [7:0] BASE_ADDR_HI   = REN_BASE_ADDR_HI
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_rd_i,
    input  logic [REN_INST_W-1:0] cmd_inst_i,
    input  logic [23:0]           cmd_offset_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  s_valid_i,
    input  logic [31:0]           s_data_i,
    output logic                  s_ready_o,
    output logic                  m_valid_o,
    output logic [31:0]           m_data_o,
    input  logic                  m_ready_i,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [3:0]            wbm_sel_o,
    output logic [31:0]           wbm_adr_o,
    output logic [31:0]           wbm_dat_o,
    input  logic [31:0]           wbm_dat_i,
    input  logic                  wbm_ack_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

    ren_state_e           state_r;
    ren_state_e           state_nxt_s;
    logic [LEN_WIDTH-1:0] len_r;
    logic [LEN_WIDTH-1:0] cnt_r;
    logic                 bus_s;
    logic                 expire_s;
    logic                 last_s;
    logic                 bus_nxt_s;

    assign bus_s     = ren_is_bus(state_r);
    assign bus_nxt_s = ren_is_bus(state_nxt_s);
    // The word completing now is the final one of the burst.
    assign last_s    = ((cnt_r + LEN_ONE) == len_r);

    ren_wb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_WIDTH       (TO_WIDTH)
    ) u_timer (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_i),
        .load   (~bus_s),
        .en     (bus_s & ~wbm_ack_i),
        .expire (expire_s)
    );

    // Next-state decision for the burst sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_len_i == LEN_ZERO) begin
                        state_nxt_s = ST_FINISH;
                    end else if (cmd_rd_i) begin
                        state_nxt_s = ST_RD_BUS;
                    end else begin
                        state_nxt_s = ST_WR_FETCH;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR_FETCH: begin
                if (s_valid_i) begin
                    state_nxt_s = ST_WR_BUS;
                end else begin
                    state_nxt_s = ST_WR_FETCH;
                end
            end
            ST_WR_BUS: begin
                if (wbm_ack_i) begin
                    state_nxt_s = last_s ? ST_FINISH : ST_WR_FETCH;
                end else if (expire_s) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_WR_BUS;
                end
            end
            ST_RD_BUS: begin
                if (wbm_ack_i) begin
                    state_nxt_s = ST_RD_PUSH;
                end else if (expire_s) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_RD_BUS;
                end
            end
            ST_RD_PUSH: begin
                if (m_ready_i) begin
                    state_nxt_s = last_s ? ST_FINISH : ST_RD_BUS;
                end else begin
                    state_nxt_s = ST_RD_PUSH;
                end
            end
            ST_FINISH: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State, registered outputs and burst datapath; outputs decode the next state.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_r     <= ST_IDLE;
            len_r       <= LEN_ZERO;
            cnt_r       <= LEN_ZERO;
            cmd_ready_o <= 1'b1;
            s_ready_o   <= 1'b0;
            m_valid_o   <= 1'b0;
            m_data_o    <= 32'h0000_0000;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= 4'h0;
            wbm_adr_o   <= 32'h0000_0000;
            wbm_dat_o   <= 32'h0000_0000;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cmd_ready_o <= (state_nxt_s == ST_IDLE);
            s_ready_o   <= (state_nxt_s == ST_WR_FETCH);
            m_valid_o   <= (state_nxt_s == ST_RD_PUSH);
            wbm_cyc_o   <= bus_nxt_s;
            wbm_stb_o   <= bus_nxt_s;
            wbm_we_o    <= (state_nxt_s == ST_WR_BUS);
            wbm_sel_o   <= bus_nxt_s ? 4'hF : 4'h0;
            busy_o      <= (state_nxt_s != ST_IDLE);
            done_o      <= (state_nxt_s == ST_FINISH);
            // expire_s already excludes an ack, so it marks exactly the abort path.
            err_o       <= expire_s;

            // The address register doubles as the running offset; the low
            // 24 bits wrap on their own and never touch the instance byte.
            if ((state_r == ST_IDLE) && cmd_valid_i) begin
                len_r     <= cmd_len_i;
                cnt_r     <= LEN_ZERO;
                wbm_adr_o <= {ren_inst_hi(BASE_ADDR_HI, cmd_inst_i), cmd_offset_i};
            end else if (((state_r == ST_WR_BUS) && wbm_ack_i) ||
                         ((state_r == ST_RD_PUSH) && m_ready_i)) begin
                cnt_r           <= cnt_r + LEN_ONE;
                wbm_adr_o[23:0] <= wbm_adr_o[23:0] + REN_BYTE_STRIDE;
            end else begin
                cnt_r     <= cnt_r;
                wbm_adr_o <= wbm_adr_o;
            end

            if ((state_r == ST_WR_FETCH) && s_valid_i) begin
                wbm_dat_o <= s_data_i;
            end else begin
                wbm_dat_o <= wbm_dat_o;
            end

            if ((state_r == ST_RD_BUS) && wbm_ack_i) begin
                m_data_o <= wbm_dat_i;
            end else begin
                m_data_o <= m_data_o;
            end
        end
    end

endmodule
